// File: rtl/lsu_dc_parity_chk.sv
// ---------------------------------------------------------------------------
// lsu_dc_parity_chk
//
// Purpose:
//   Receiving-end parity checker for D-cache read data. Every WIDTH-bit lane
//   of a read is re-hashed (XOR reduction) and compared with the parity bit
//   that was stored alongside it. Per-lane mismatches come out two cycles
//   after the request. A sticky first-error log and a saturating error
//   counter are kept for the LSU error-reporting logic.
//
// Ports:
//   rclk       clock
//   reset      asynchronous, active-high reset
//   chk_vld    check request this cycle
//   chk_data   D-cache read data, WIDTH*NUM bits
//   chk_par    stored parity, bit i covers chk_data[WIDTH*i +: WIDTH]
//   chk_addr   address tag carried with the check
//   chk_tid    requesting thread
//   chk_flush  kill every in-flight check
//   chk_done   stage-2 result valid
//   err_vld    stage-2 result valid with at least one lane mismatched
//   err_byte   per-lane mismatch mask, zero when chk_done=0
//   log_vld    error log holds a captured error
//   log_ovf    another error arrived while the log was full
//   log_addr   address of the first logged error
//   log_byte   lane mask of the first logged error
//   log_tid    thread of the first logged error
//   log_cnt    saturating count of erroring checks
//   log_clr    one-cycle pulse clearing the log and the counter
//
// Optional feature (macro LSU_DC_PAR_INJECT_EN):
//   Adds inj_arm / inj_mask. A pulse on inj_arm arms inj_mask; the next
//   valid, unflushed check entering stage 1 has the mask XORed into its
//   stored parity, forcing mismatches on those lanes. The arm is one-shot.
// ---------------------------------------------------------------------------
module lsu_dc_parity_chk #(
  parameter int WIDTH  = 8,
  parameter int NUM    = 16,
  parameter int ADDR_W = 11,
  parameter int CNT_W  = 8
) (
  input  logic                 rclk,
  input  logic                 reset,
  input  logic                 chk_vld,
  input  logic [WIDTH*NUM-1:0] chk_data,
  input  logic [NUM-1:0]       chk_par,
  input  logic [ADDR_W-1:0]    chk_addr,
  input  logic [1:0]           chk_tid,
  input  logic                 chk_flush,
`ifdef LSU_DC_PAR_INJECT_EN
  input  logic                 inj_arm,
  input  logic [NUM-1:0]       inj_mask,
`endif
  output logic                 chk_done,
  output logic                 err_vld,
  output logic [NUM-1:0]       err_byte,
  output logic                 log_vld,
  output logic                 log_ovf,
  output logic [ADDR_W-1:0]    log_addr,
  output logic [NUM-1:0]       log_byte,
  output logic [1:0]           log_tid,
  output logic [CNT_W-1:0]     log_cnt,
  input  logic                 log_clr
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOGGED = 2'd1;
  localparam logic [1:0] ST_OVF    = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic                 r_s1_vld;
  logic [WIDTH*NUM-1:0] r_s1_data;
  logic [NUM-1:0]       r_s1_par;
  logic [ADDR_W-1:0]    r_s1_addr;
  logic [1:0]           r_s1_tid;

  logic                 r_s2_vld;
  logic [NUM-1:0]       r_s2_err;
  logic [ADDR_W-1:0]    r_s2_addr;
  logic [1:0]           r_s2_tid;

  logic [1:0]           r_log_state;
  logic [ADDR_W-1:0]    r_log_addr;
  logic [NUM-1:0]       r_log_byte;
  logic [1:0]           r_log_tid;
  logic [CNT_W-1:0]     r_log_cnt;

  logic                 w_s1_load;
  logic [NUM-1:0]       w_par_in;
  logic [NUM-1:0]       w_mismatch;
  logic                 w_err_vld;
  logic [CNT_W-1:0]     w_cnt_inc;

  // A request presented together with a flush never enters the pipe.
  assign w_s1_load = chk_vld & ~chk_flush;

`ifdef LSU_DC_PAR_INJECT_EN
  logic [NUM-1:0] r_inj_armed;

  // The armed mask only matters for a check that is actually loaded, so
  // XOR it in unconditionally; a non-loaded stage-1 entry is invalid anyway.
  assign w_par_in = chk_par ^ r_inj_armed;

  // A fresh arm pulse always wins, even when the old mask is being
  // consumed in the same cycle.
  always_ff @(posedge rclk or posedge reset) begin
    if (reset) begin
      r_inj_armed <= '0;
    end else if (inj_arm) begin
      r_inj_armed <= inj_mask;
    end else if (w_s1_load) begin
      r_inj_armed <= '0;
    end
  end
`else
  assign w_par_in = chk_par;
`endif

  // Stage 1: capture the raw request.
  always_ff @(posedge rclk or posedge reset) begin
    if (reset) begin
      r_s1_vld  <= 1'b0;
      r_s1_data <= '0;
      r_s1_par  <= '0;
      r_s1_addr <= '0;
      r_s1_tid  <= '0;
    end else begin
      r_s1_vld  <= w_s1_load;
      r_s1_data <= chk_data;
      r_s1_par  <= w_par_in;
      r_s1_addr <= chk_addr;
      r_s1_tid  <= chk_tid;
    end
  end

  // Per-lane recomputed parity against the stored bit.
  for (genvar gi = 0; gi < NUM; gi++) begin : g_lane
    assign w_mismatch[gi] = (^r_s1_data[WIDTH*gi +: WIDTH]) ^ r_s1_par[gi];
  end

  // Stage 2: register the mismatch vector; a flush kills the stage-1 entry
  // on its way in.
  always_ff @(posedge rclk or posedge reset) begin
    if (reset) begin
      r_s2_vld  <= 1'b0;
      r_s2_err  <= '0;
      r_s2_addr <= '0;
      r_s2_tid  <= '0;
    end else begin
      r_s2_vld  <= r_s1_vld & ~chk_flush;
      r_s2_err  <= w_mismatch;
      r_s2_addr <= r_s1_addr;
      r_s2_tid  <= r_s1_tid;
    end
  end

  assign w_err_vld = r_s2_vld & (|r_s2_err);
  assign w_cnt_inc = (r_log_cnt == CNT_MAX) ? r_log_cnt : r_log_cnt + CNT_W'(1);

  // Log state machine. A clear colliding with an error restarts the log
  // with that error as the first capture, so the counter restarts at one.
  always_ff @(posedge rclk or posedge reset) begin
    if (reset) begin
      r_log_state <= ST_IDLE;
      r_log_addr  <= '0;
      r_log_byte  <= '0;
      r_log_tid   <= '0;
      r_log_cnt   <= '0;
    end else if (w_err_vld && (log_clr || r_log_state == ST_IDLE)) begin
      r_log_state <= ST_LOGGED;
      r_log_addr  <= r_s2_addr;
      r_log_byte  <= r_s2_err;
      r_log_tid   <= r_s2_tid;
      r_log_cnt   <= log_clr ? CNT_W'(1) : w_cnt_inc;
    end else if (log_clr) begin
      r_log_state <= ST_IDLE;
      r_log_cnt   <= '0;
    end else if (w_err_vld) begin
      r_log_state <= ST_OVF;
      r_log_cnt   <= w_cnt_inc;
    end
  end

  assign chk_done = r_s2_vld;
  assign err_vld  = w_err_vld;
  assign err_byte = r_s2_vld ? r_s2_err : '0;
  assign log_vld  = (r_log_state != ST_IDLE);
  assign log_ovf  = (r_log_state == ST_OVF);
  assign log_addr = r_log_addr;
  assign log_byte = r_log_byte;
  assign log_tid  = r_log_tid;
  assign log_cnt  = r_log_cnt;

endmodule

// File: tb/tb_lsu_dc_parity_chk.sv
// ---------------------------------------------------------------------------
// tb_lsu_dc_parity_chk
//
// Directed self-checking bench for lsu_dc_parity_chk. Inputs change 1 time
// unit after each rising edge; outputs are compared in the same window.
// Define LSU_DC_PAR_INJECT_EN to also exercise the parity-injection path.
// ---------------------------------------------------------------------------
module tb_lsu_dc_parity_chk;

  localparam int WIDTH  = 8;
  localparam int NUM    = 16;
  localparam int ADDR_W = 11;
  localparam int CNT_W  = 8;

  logic                 rclk;
  logic                 reset;
  logic                 chk_vld;
  logic [WIDTH*NUM-1:0] chk_data;
  logic [NUM-1:0]       chk_par;
  logic [ADDR_W-1:0]    chk_addr;
  logic [1:0]           chk_tid;
  logic                 chk_flush;
  logic                 chk_done;
  logic                 err_vld;
  logic [NUM-1:0]       err_byte;
  logic                 log_vld;
  logic                 log_ovf;
  logic [ADDR_W-1:0]    log_addr;
  logic [NUM-1:0]       log_byte;
  logic [1:0]           log_tid;
  logic [CNT_W-1:0]     log_cnt;
  logic                 log_clr;
`ifdef LSU_DC_PAR_INJECT_EN
  logic                 inj_arm;
  logic [NUM-1:0]       inj_mask;
`endif

  int errCount;
  int checkCount;

  lsu_dc_parity_chk #(
    .WIDTH(WIDTH), .NUM(NUM), .ADDR_W(ADDR_W), .CNT_W(CNT_W)
  ) dut (
    .rclk(rclk),
    .reset(reset),
    .chk_vld(chk_vld),
    .chk_data(chk_data),
    .chk_par(chk_par),
    .chk_addr(chk_addr),
    .chk_tid(chk_tid),
    .chk_flush(chk_flush),
`ifdef LSU_DC_PAR_INJECT_EN
    .inj_arm(inj_arm),
    .inj_mask(inj_mask),
`endif
    .chk_done(chk_done),
    .err_vld(err_vld),
    .err_byte(err_byte),
    .log_vld(log_vld),
    .log_ovf(log_ovf),
    .log_addr(log_addr),
    .log_byte(log_byte),
    .log_tid(log_tid),
    .log_cnt(log_cnt),
    .log_clr(log_clr)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  // Compare one observed value with its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [127:0] got,
                             input logic [127:0] exp);
    checkCount++;
    if (got !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Drive one request onto the check inputs for the current cycle.
  task automatic applyStimulus(input logic vld, input logic [127:0] data,
                               input logic [15:0] par, input logic [10:0] addr,
                               input logic [1:0] tid);
    chk_vld  = vld;
    chk_data = data;
    chk_par  = par;
    chk_addr = addr;
    chk_tid  = tid;
  endtask

  // Advance to just after the next rising edge.
  task automatic nextCycle();
    @(posedge rclk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, '0, '0, '0, 2'd0);
  endtask

  initial begin
    errCount   = 0;
    checkCount = 0;
    reset      = 1'b1;
    chk_flush  = 1'b0;
    log_clr    = 1'b0;
`ifdef LSU_DC_PAR_INJECT_EN
    inj_arm    = 1'b0;
    inj_mask   = '0;
`endif
    idle();
    nextCycle();
    nextCycle();

    // Reset state
    checkOutput("rst_done",   chk_done, 0);
    checkOutput("rst_errvld", err_vld,  0);
    checkOutput("rst_errbyte", err_byte, 0);
    checkOutput("rst_logvld", log_vld,  0);
    checkOutput("rst_logovf", log_ovf,  0);
    checkOutput("rst_logaddr", log_addr, 0);
    checkOutput("rst_logbyte", log_byte, 0);
    checkOutput("rst_logtid", log_tid,  0);
    checkOutput("rst_logcnt", log_cnt,  0);
    reset = 1'b0;
    nextCycle();

    // Clean data, two back-to-back checks
    applyStimulus(1'b1, 128'h0, 16'h0000, 11'h001, 2'd0);
    nextCycle();
    applyStimulus(1'b1, 128'h01, 16'h0001, 11'h002, 2'd1);
    checkOutput("clean_lat1_done", chk_done, 0);
    nextCycle();
    idle();
    checkOutput("clean_a_done", chk_done, 1);
    checkOutput("clean_a_err", err_vld, 0);
    checkOutput("clean_a_byte", err_byte, 0);
    nextCycle();
    checkOutput("clean_b_done", chk_done, 1);
    checkOutput("clean_b_err", err_vld, 0);
    checkOutput("clean_b_byte", err_byte, 0);
    nextCycle();
    checkOutput("clean_done_off", chk_done, 0);
    checkOutput("clean_logvld", log_vld, 0);

    // Single lane error on lane 1
    applyStimulus(1'b1, 128'h0100, 16'h0000, 11'h155, 2'd2);
    nextCycle();
    idle();
    nextCycle();
    checkOutput("single_errvld", err_vld, 1);
    checkOutput("single_errbyte", err_byte, 16'h0002);
    checkOutput("single_logvld_pre", log_vld, 0);
    nextCycle();
    checkOutput("single_logvld", log_vld, 1);
    checkOutput("single_logaddr", log_addr, 11'h155);
    checkOutput("single_logbyte", log_byte, 16'h0002);
    checkOutput("single_logtid", log_tid, 2);
    checkOutput("single_logcnt", log_cnt, 1);
    checkOutput("single_logovf", log_ovf, 0);

    // Clear the log
    log_clr = 1'b1;
    nextCycle();
    log_clr = 1'b0;
    checkOutput("clr_logvld", log_vld, 0);
    checkOutput("clr_logcnt", log_cnt, 0);

    // Two back-to-back errors: lane 15, then lanes 4..7
    applyStimulus(1'b1, {8'h80, 120'h0}, 16'h0000, 11'h010, 2'd1);
    nextCycle();
    applyStimulus(1'b1, 128'h0, 16'h00F0, 11'h020, 2'd3);
    nextCycle();
    idle();
    checkOutput("two_a_byte", err_byte, 16'h8000);
    nextCycle();
    checkOutput("two_b_byte", err_byte, 16'h00F0);
    checkOutput("two_mid_logaddr", log_addr, 11'h010);
    checkOutput("two_mid_logovf", log_ovf, 0);
    checkOutput("two_mid_logcnt", log_cnt, 1);
    nextCycle();
    checkOutput("two_logaddr", log_addr, 11'h010);
    checkOutput("two_logbyte", log_byte, 16'h8000);
    checkOutput("two_logtid", log_tid, 1);
    checkOutput("two_logovf", log_ovf, 1);
    checkOutput("two_logcnt", log_cnt, 2);

    // Clear collides with a new error
    applyStimulus(1'b1, 128'h01, 16'h0000, 11'h3FF, 2'd0);
    nextCycle();
    idle();
    nextCycle();
    log_clr = 1'b1;
    checkOutput("coll_errvld", err_vld, 1);
    nextCycle();
    log_clr = 1'b0;
    checkOutput("coll_logvld", log_vld, 1);
    checkOutput("coll_logaddr", log_addr, 11'h3FF);
    checkOutput("coll_logovf", log_ovf, 0);
    checkOutput("coll_logcnt", log_cnt, 1);

    // 300 erroring checks saturate the counter
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b1, 128'h0, 16'hFFFF, 11'h0AA, 2'd2);
      nextCycle();
    end
    idle();
    nextCycle();
    nextCycle();
    nextCycle();
    checkOutput("sat_logcnt", log_cnt, 255);
    checkOutput("sat_logovf", log_ovf, 1);
    checkOutput("sat_logaddr", log_addr, 11'h3FF);

    // Erroring check flushed while in stage 1
    applyStimulus(1'b1, 128'h01, 16'h0000, 11'h044, 2'd1);
    nextCycle();
    idle();
    chk_flush = 1'b1;
    nextCycle();
    chk_flush = 1'b0;
    checkOutput("flush1_done", chk_done, 0);
    checkOutput("flush1_errbyte", err_byte, 0);
    nextCycle();
    checkOutput("flush1_logcnt", log_cnt, 255);

    // Request presented together with a flush is dropped
    applyStimulus(1'b1, 128'h01, 16'h0000, 11'h055, 2'd1);
    chk_flush = 1'b1;
    nextCycle();
    chk_flush = 1'b0;
    idle();
    nextCycle();
    checkOutput("flush0_done", chk_done, 0);
    checkOutput("flush0_errvld", err_vld, 0);

`ifdef LSU_DC_PAR_INJECT_EN
    // Armed injection hits exactly one clean check
    inj_arm  = 1'b1;
    inj_mask = 16'h8001;
    nextCycle();
    inj_arm  = 1'b0;
    inj_mask = '0;
    applyStimulus(1'b1, 128'h0, 16'h0000, 11'h066, 2'd0);
    nextCycle();
    applyStimulus(1'b1, 128'h0, 16'h0000, 11'h067, 2'd0);
    nextCycle();
    idle();
    checkOutput("inj_a_byte", err_byte, 16'h8001);
    checkOutput("inj_a_done", chk_done, 1);
    nextCycle();
    checkOutput("inj_b_byte", err_byte, 16'h0000);
    checkOutput("inj_b_done", chk_done, 1);
    nextCycle();
`endif

    // Reset mid-operation discards the in-flight check and the log
    applyStimulus(1'b1, 128'h01, 16'h0000, 11'h077, 2'd3);
    nextCycle();
    idle();
    reset = 1'b1;
    #1;
    checkOutput("midrst_logcnt", log_cnt, 0);
    checkOutput("midrst_logvld", log_vld, 0);
    checkOutput("midrst_logaddr", log_addr, 0);
    reset = 1'b0;
    nextCycle();
    checkOutput("midrst_done", chk_done, 0);
    nextCycle();
    checkOutput("midrst_cnt_after", log_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
